// File: rtl/multicycle_fsm.sv
// Multicycle RISC-V style control FSM (Moore).
// Sequences fetch / decode / execute / memory / writeback for a datapath
// with one shared memory port. Optional macro BRANCH_FULL_EN widens the
// branch condition decode to the full set of compare conditions. Without it,
// only beq/bne are decoded.
// Handshake: mem_ready is a completion strobe from the memory. An access
// (fetch, load, store) is held with its controls stable every cycle until
// mem_ready=1 is seen. That cycle completes the access, and the FSM advances
// on the same edge.
module multicycle_fsm (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       N,
  input  logic       Z,
  input  logic       C,
  input  logic       V,
  input  logic       mem_ready,
  output logic       pc_wren,
  output logic       ir_wren,
  output logic       dmem_wren,
  output logic       regfile_wren,
  output logic       adr_sel,
  output logic [1:0] alu_asel,
  output logic [1:0] alu_bsel,
  output logic [1:0] result_sel,
  output logic [2:0] ximm_sel,
  output logic [1:0] ALU_op,
  output logic       illegal,
  output logic [3:0] dbg_state_o
);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  // Mux select encodings seen by the datapath.
  localparam logic [1:0] ASEL_PC    = 2'b00;
  localparam logic [1:0] ASEL_OLDPC = 2'b01;
  localparam logic [1:0] ASEL_RS1   = 2'b10;
  localparam logic [1:0] ASEL_ZERO  = 2'b11;
  localparam logic [1:0] BSEL_RS2   = 2'b00;
  localparam logic [1:0] BSEL_IMM   = 2'b01;
  localparam logic [1:0] BSEL_FOUR  = 2'b10;
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MDR    = 2'b01;
  localparam logic [1:0] RES_LIVE   = 2'b10;
  localparam logic [2:0] IMM_I      = 3'd0;
  localparam logic [2:0] IMM_S      = 3'd1;
  localparam logic [2:0] IMM_B      = 3'd2;
  localparam logic [2:0] IMM_U      = 3'd4;
  localparam logic [1:0] ALU_ADD    = 2'b00;
  localparam logic [1:0] ALU_SUB    = 2'b01;
  localparam logic [1:0] ALU_FUNCT  = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JALR_ADR = 4'd10,
    S_JAL      = 4'd11,
    S_LUI      = 4'd12,
    S_AUIPC    = 4'd13,
    S_TRAP     = 4'd14
  } state_t;

  state_t state_q, state_d;

  // The IR is only stable after FETCH. Only DECODE, MEMADR and BRANCH
  // consume these classes or funct3.
  logic op_mem, op_store;
  logic br_taken;

  // Opcode classes used for dispatch and load/store selection.
  always_comb begin
    op_mem   = (opcode == OP_LOAD) || (opcode == OP_STORE);
    op_store = (opcode == OP_STORE);
  end

`ifdef BRANCH_FULL_EN
  // Branch condition from the compare flags (rs1 - rs2) for all branch types.
  always_comb begin
    br_taken = 1'b0;
    case (funct3)
      3'b000:  br_taken = Z;
      3'b001:  br_taken = !Z;
      3'b100:  br_taken = N ^ V;
      3'b101:  br_taken = !(N ^ V);
      3'b110:  br_taken = !C;
      3'b111:  br_taken = C;
      default: br_taken = 1'b0;
    endcase
  end

  // funct7b5 is routed to the datapath ALU decode, not used here.
  logic unused_inputs;
  assign unused_inputs = funct7b5;
`else
  // Reduced branch decode: only beq/bne. Every other funct3 is not taken.
  always_comb begin
    br_taken = 1'b0;
    if (funct3 == 3'b000) begin
      br_taken = Z;
    end else if (funct3 == 3'b001) begin
      br_taken = !Z;
    end
  end

  // N/C/V only matter for the full branch set. funct7b5 belongs to the
  // datapath.
  logic unused_inputs;
  assign unused_inputs = ^{funct7b5, N, C, V};
`endif

  // State register. Reset wins from any state, including waits and TRAP.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH: begin
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        if (op_mem)                    state_d = S_MEMADR;
        else if (opcode == OP_R)       state_d = S_EXECR;
        else if (opcode == OP_I)       state_d = S_EXECI;
        else if (opcode == OP_BR)      state_d = S_BRANCH;
        else if (opcode == OP_JAL)     state_d = S_JAL;
        else if (opcode == OP_JALR)    state_d = S_JALR_ADR;
        else if (opcode == OP_LUI)     state_d = S_LUI;
        else if (opcode == OP_AUIPC)   state_d = S_AUIPC;
        else                           state_d = S_TRAP;
      end
      S_MEMADR:   state_d = op_store ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD: begin
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: begin
        if (mem_ready) state_d = S_FETCH;
      end
      S_EXECR:    state_d = S_ALUWB;
      S_EXECI:    state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      S_JALR_ADR: state_d = S_JAL;
      S_JAL:      state_d = S_ALUWB;
      S_LUI:      state_d = S_ALUWB;
      S_AUIPC:    state_d = S_ALUWB;
      S_TRAP:     state_d = S_TRAP;
      default:    state_d = S_FETCH;
    endcase
  end

  // Outputs. Each state lists only what it drives. Everything else is 0.
  // Reset masks every enable and illegal, so no stray writes occur.
  always_comb begin
    pc_wren      = 1'b0;
    ir_wren      = 1'b0;
    dmem_wren    = 1'b0;
    regfile_wren = 1'b0;
    adr_sel      = 1'b0;
    alu_asel     = ASEL_PC;
    alu_bsel     = BSEL_RS2;
    result_sel   = RES_ALUOUT;
    ximm_sel     = IMM_I;
    ALU_op       = ALU_ADD;
    illegal      = 1'b0;
    case (state_q)
      S_FETCH: begin
        // PC+4 computed live. PC and IR both latch when the fetch completes.
        alu_asel   = ASEL_PC;
        alu_bsel   = BSEL_FOUR;
        result_sel = RES_LIVE;
        ir_wren    = mem_ready;
        pc_wren    = mem_ready;
      end
      S_DECODE: begin
        // Speculatively compute oldPC + B-imm for a possible branch.
        alu_asel = ASEL_OLDPC;
        alu_bsel = BSEL_IMM;
        ximm_sel = IMM_B;
      end
      S_MEMADR: begin
        alu_asel = ASEL_RS1;
        alu_bsel = BSEL_IMM;
        ximm_sel = op_store ? IMM_S : IMM_I;
      end
      S_MEMREAD: begin
        adr_sel    = 1'b1;
        result_sel = RES_ALUOUT;
      end
      S_MEMWB: begin
        result_sel   = RES_MDR;
        regfile_wren = 1'b1;
      end
      S_MEMWRITE: begin
        adr_sel    = 1'b1;
        result_sel = RES_ALUOUT;
        dmem_wren  = 1'b1;
      end
      S_EXECR: begin
        alu_asel = ASEL_RS1;
        alu_bsel = BSEL_RS2;
        ALU_op   = ALU_FUNCT;
      end
      S_EXECI: begin
        alu_asel = ASEL_RS1;
        alu_bsel = BSEL_IMM;
        ximm_sel = IMM_I;
        ALU_op   = ALU_FUNCT;
      end
      S_ALUWB: begin
        result_sel   = RES_ALUOUT;
        regfile_wren = 1'b1;
      end
      S_BRANCH: begin
        // Compare rs1 - rs2. The target from DECODE sits in ALU-out.
        alu_asel   = ASEL_RS1;
        alu_bsel   = BSEL_RS2;
        ALU_op     = ALU_SUB;
        result_sel = RES_ALUOUT;
        pc_wren    = br_taken;
      end
      S_JALR_ADR: begin
        alu_asel = ASEL_RS1;
        alu_bsel = BSEL_IMM;
        ximm_sel = IMM_I;
      end
      S_JAL: begin
        // Jump to the target in ALU-out while computing the link oldPC+4.
        alu_asel   = ASEL_OLDPC;
        alu_bsel   = BSEL_FOUR;
        result_sel = RES_ALUOUT;
        pc_wren    = 1'b1;
      end
      S_LUI: begin
        alu_asel = ASEL_ZERO;
        alu_bsel = BSEL_IMM;
        ximm_sel = IMM_U;
      end
      S_AUIPC: begin
        alu_asel = ASEL_OLDPC;
        alu_bsel = BSEL_IMM;
        ximm_sel = IMM_U;
      end
      S_TRAP: begin
        illegal = 1'b1;
      end
      default: begin
        illegal = 1'b0;
      end
    endcase
    if (reset) begin
      pc_wren      = 1'b0;
      ir_wren      = 1'b0;
      dmem_wren    = 1'b0;
      regfile_wren = 1'b0;
      illegal      = 1'b0;
    end
  end

  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_multicycle_fsm.sv
// Testbench for multicycle_fsm: directed table, hand-written reset corner
// cases, and randomized instructions checked cycle by cycle against an
// instruction-level reference model.
module tb_multicycle_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       N, Z, C, V;
  logic       mem_ready;
  logic       pc_wren, ir_wren, dmem_wren, regfile_wren, adr_sel, illegal;
  logic [1:0] alu_asel, alu_bsel, result_sel, ALU_op;
  logic [2:0] ximm_sel;
  logic [3:0] dbg_state;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  multicycle_fsm dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3),
    .funct7b5(funct7b5), .N(N), .Z(Z), .C(C), .V(V), .mem_ready(mem_ready),
    .pc_wren(pc_wren), .ir_wren(ir_wren), .dmem_wren(dmem_wren),
    .regfile_wren(regfile_wren), .adr_sel(adr_sel), .alu_asel(alu_asel),
    .alu_bsel(alu_bsel), .result_sel(result_sel), .ximm_sel(ximm_sel),
    .ALU_op(ALU_op), .illegal(illegal), .dbg_state_o(dbg_state)
  );

  // Packed output vector {pc,ir,dm,rf,adr,asel,bsel,rsel,ximm,aluop,illegal}.
  logic [16:0] dut_v;
  assign dut_v = {pc_wren, ir_wren, dmem_wren, regfile_wren, adr_sel, alu_asel,
                  alu_bsel, result_sel, ximm_sel, ALU_op, illegal};

  // ---------------- scoreboard ----------------
  logic [16:0] exp_q[$];
  logic        mr_q[$];
  logic        rst_q[$];
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int cnt_pc, cnt_rf, cnt_dm;

  task automatic check_vec(input string name, input logic [16:0] got, input logic [16:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s cyc=%0d op=%b f3=%b got=%h want=%h", name, cyc, opcode, funct3, got, want);
    end
  endtask

  task automatic check_int(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s op=%b f3=%b got=%0d want=%0d", name, opcode, funct3, got, want);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [16:0] ov(input logic pc, ir, dm, rf, adr,
                                     input logic [1:0] as, bs, rs,
                                     input logic [2:0] xi,
                                     input logic [1:0] op,
                                     input logic il);
    return {pc, ir, dm, rf, adr, as, bs, rs, xi, op, il};
  endfunction

  function automatic logic tb_taken(input logic [2:0] f3, input logic n, z, c, v);
`ifdef BRANCH_FULL_EN
    case (f3)
      3'd0: return z;
      3'd1: return !z;
      3'd4: return n ^ v;
      3'd5: return !(n ^ v);
      3'd6: return !c;
      3'd7: return c;
      default: return 1'b0;
    endcase
`else
    if (f3 == 3'd0) return z;
    if (f3 == 3'd1) return !z;
    return 1'b0;
`endif
  endfunction

  task automatic push(input logic mr, input logic rs, input logic [16:0] e);
    mr_q.push_back(mr);
    rst_q.push_back(rs);
    exp_q.push_back(e);
  endtask

  function automatic logic rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  // Named per-step expectations, from the per-state output lists.
  function automatic logic [16:0] e_fetch(input logic done);
    return ov(done, done, 0, 0, 0, 2'b00, 2'b10, 2'b10, 3'd0, 2'b00, 0);
  endfunction

  function automatic logic [16:0] e_alu(input logic [1:0] as, bs, input logic [2:0] xi, input logic [1:0] op);
    return ov(0, 0, 0, 0, 0, as, bs, 2'b00, xi, op, 0);
  endfunction

  localparam logic [16:0] E_WB_ALU = 17'h0 | (17'b1 << 13);          // regfile_wren only
  localparam logic [16:0] E_MEMRD  = 17'h0 | (17'b1 << 12);          // adr_sel only

  // Fetch phase with fw wait cycles.
  task automatic model_fetch(input int fw);
    for (int i = 0; i < fw; i++) push(1'b0, 1'b0, e_fetch(1'b0));
    push(1'b1, 1'b0, e_fetch(1'b1));
  endtask

  // Whole instruction: fetch, decode, then the opcode-specific steps.
  // Illegal opcodes trap for a few cycles and are released by a reset cycle.
  task automatic model_instr(input logic [6:0] op, input logic [2:0] f3, input logic [3:0] nzcv,
                             input int fw, input int mw);
    model_fetch(fw);
    push(rnd(), 1'b0, e_alu(2'b01, 2'b01, 3'd2, 2'b00));
    case (op)
      7'b0000011: begin
        push(rnd(), 1'b0, e_alu(2'b10, 2'b01, 3'd0, 2'b00));
        for (int i = 0; i < mw; i++) push(1'b0, 1'b0, E_MEMRD);
        push(1'b1, 1'b0, E_MEMRD);
        push(rnd(), 1'b0, ov(0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b01, 3'd0, 2'b00, 0));
      end
      7'b0100011: begin
        push(rnd(), 1'b0, e_alu(2'b10, 2'b01, 3'd1, 2'b00));
        for (int i = 0; i <= mw; i++)
          push(i == mw, 1'b0, ov(0, 0, 1, 0, 1, 2'b00, 2'b00, 2'b00, 3'd0, 2'b00, 0));
      end
      7'b0110011: begin
        push(rnd(), 1'b0, e_alu(2'b10, 2'b00, 3'd0, 2'b10));
        push(rnd(), 1'b0, E_WB_ALU);
      end
      7'b0010011: begin
        push(rnd(), 1'b0, e_alu(2'b10, 2'b01, 3'd0, 2'b10));
        push(rnd(), 1'b0, E_WB_ALU);
      end
      7'b1100011: begin
        push(rnd(), 1'b0, ov(tb_taken(f3, nzcv[3], nzcv[2], nzcv[1], nzcv[0]), 0, 0, 0, 0,
                             2'b10, 2'b00, 2'b00, 3'd0, 2'b01, 0));
      end
      7'b1101111, 7'b1100111: begin
        if (op == 7'b1100111) push(rnd(), 1'b0, e_alu(2'b10, 2'b01, 3'd0, 2'b00));
        push(rnd(), 1'b0, ov(1, 0, 0, 0, 0, 2'b01, 2'b10, 2'b00, 3'd0, 2'b00, 0));
        push(rnd(), 1'b0, E_WB_ALU);
      end
      7'b0110111: begin
        push(rnd(), 1'b0, e_alu(2'b11, 2'b01, 3'd4, 2'b00));
        push(rnd(), 1'b0, E_WB_ALU);
      end
      7'b0010111: begin
        push(rnd(), 1'b0, e_alu(2'b01, 2'b01, 3'd4, 2'b00));
        push(rnd(), 1'b0, E_WB_ALU);
      end
      default: begin
        for (int i = 0; i < 3; i++) push(rnd(), 1'b0, ov(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        push(rnd(), 1'b1, 17'h0);
      end
    endcase
  endtask

  // ---------------- driver ----------------
  task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic [3:0] nzcv);
    opcode = op; funct3 = f3; funct7b5 = rnd();
    {N, Z, C, V} = nzcv;
  endtask

  // Apply queued per-cycle inputs, compare at negedge, tally enables.
  task automatic run_queue();
    logic mr, rs;
    logic [16:0] e;
    while (exp_q.size() > 0) begin
      mr = mr_q.pop_front();
      rs = rst_q.pop_front();
      e  = exp_q.pop_front();
      mem_ready = mr;
      reset = rs;
      @(negedge clk);
      check_vec("cycle", dut_v, e);
      cnt_pc += int'(pc_wren);
      cnt_rf += int'(regfile_wren);
      cnt_dm += int'(dmem_wren);
      @(posedge clk);
      #1;
      cyc++;
    end
    reset = 1'b0;
  endtask

  task automatic clear_counts();
    cnt_pc = 0; cnt_rf = 0; cnt_dm = 0;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    string      name;
    logic [6:0] op;
    logic [2:0] f3;
    logic [3:0] nzcv;
    int         fw;
    int         mw;
    int         exp_pc;
    int         exp_rf;
    int         exp_dm;
  } vec_t;

  vec_t tbl[15];

  initial begin
    tbl[0]  = '{"lw",         7'b0000011, 3'd2, 4'b0000, 0, 0, 1, 1, 0};
    tbl[1]  = '{"lw_wait",    7'b0000011, 3'd2, 4'b0000, 2, 3, 1, 1, 0};
    tbl[2]  = '{"sw_wait3",   7'b0100011, 3'd2, 4'b0000, 0, 3, 1, 0, 4};
    tbl[3]  = '{"sw",         7'b0100011, 3'd2, 4'b0000, 1, 0, 1, 0, 1};
    tbl[4]  = '{"rtype",      7'b0110011, 3'd0, 4'b0000, 0, 0, 1, 1, 0};
    tbl[5]  = '{"itype",      7'b0010011, 3'd0, 4'b0000, 0, 0, 1, 1, 0};
    tbl[6]  = '{"beq_z1",     7'b1100011, 3'd0, 4'b0100, 0, 0, 2, 0, 0};
    tbl[7]  = '{"beq_z0",     7'b1100011, 3'd0, 4'b0000, 0, 0, 1, 0, 0};
    tbl[8]  = '{"bne_z0",     7'b1100011, 3'd1, 4'b0000, 0, 0, 2, 0, 0};
`ifdef BRANCH_FULL_EN
    tbl[9]  = '{"blt_n1v0",   7'b1100011, 3'd4, 4'b1000, 0, 0, 2, 0, 0};
    tbl[10] = '{"bgeu_c1",    7'b1100011, 3'd7, 4'b0010, 0, 0, 2, 0, 0};
`else
    tbl[9]  = '{"blt_n1v0",   7'b1100011, 3'd4, 4'b1000, 0, 0, 1, 0, 0};
    tbl[10] = '{"bgeu_c1",    7'b1100011, 3'd7, 4'b0010, 0, 0, 1, 0, 0};
`endif
    tbl[11] = '{"jal",        7'b1101111, 3'd0, 4'b0000, 0, 0, 2, 1, 0};
    tbl[12] = '{"jalr",       7'b1100111, 3'd0, 4'b0000, 0, 0, 2, 1, 0};
    tbl[13] = '{"lui",        7'b0110111, 3'd0, 4'b0000, 0, 0, 1, 1, 0};
    tbl[14] = '{"trap",       7'b1111111, 3'd0, 4'b0000, 0, 0, 1, 0, 0};
  end

  // ---------------- test sequence ----------------
  initial begin
    logic [3:0] nzcv;
    reset = 1'b1; mem_ready = 1'b1;
    set_instr(7'b0000011, 3'd0, 4'b0000);
    @(posedge clk); #1;
    @(posedge clk); #1;
    // In FETCH under reset with mem_ready=1: no enables may fire.
    @(negedge clk);
    check_vec("reset_state", dut_v, e_fetch(1'b0));
    @(posedge clk); #1;
    reset = 1'b0;

    // Directed table
    for (int t = 0; t < 15; t++) begin
      set_instr(tbl[t].op, tbl[t].f3, tbl[t].nzcv);
      clear_counts();
      model_instr(tbl[t].op, tbl[t].f3, tbl[t].nzcv, tbl[t].fw, tbl[t].mw);
      run_queue();
      check_int({tbl[t].name, "_pc"}, cnt_pc, tbl[t].exp_pc);
      check_int({tbl[t].name, "_rf"}, cnt_rf, tbl[t].exp_rf);
      check_int({tbl[t].name, "_dm"}, cnt_dm, tbl[t].exp_dm);
    end

    // Reset while MEMREAD is waiting: back to FETCH, nothing written.
    set_instr(7'b0000011, 3'd2, 4'b0000);
    clear_counts();
    model_fetch(0);
    push(1'b0, 1'b0, e_alu(2'b01, 2'b01, 3'd2, 2'b00));
    push(1'b0, 1'b0, e_alu(2'b10, 2'b01, 3'd0, 2'b00));
    push(1'b0, 1'b0, E_MEMRD);
    push(1'b0, 1'b0, E_MEMRD);
    push(1'b1, 1'b1, E_MEMRD);
    run_queue();
    check_int("memread_rst_rf", cnt_rf, 0);
    set_instr(7'b0110011, 3'd0, 4'b0000);
    model_instr(7'b0110011, 3'd0, 4'b0000, 0, 0);
    run_queue();

    // Reset while MEMWRITE is waiting: dmem_wren masked, then FETCH.
    set_instr(7'b0100011, 3'd2, 4'b0000);
    clear_counts();
    model_fetch(1);
    push(1'b0, 1'b0, e_alu(2'b01, 2'b01, 3'd2, 2'b00));
    push(1'b0, 1'b0, e_alu(2'b10, 2'b01, 3'd1, 2'b00));
    push(1'b0, 1'b0, ov(0, 0, 1, 0, 1, 2'b00, 2'b00, 2'b00, 3'd0, 2'b00, 0));
    push(1'b1, 1'b1, E_MEMRD);
    run_queue();
    check_int("memwrite_rst_dm", cnt_dm, 1);
    set_instr(7'b0110111, 3'd0, 4'b0000);
    model_instr(7'b0110111, 3'd0, 4'b0000, 0, 0);
    run_queue();

    // Long trap: illegal must hold until reset.
    set_instr(7'b1111111, 3'd0, 4'b0000);
    model_fetch(0);
    push(1'b0, 1'b0, e_alu(2'b01, 2'b01, 3'd2, 2'b00));
    for (int i = 0; i < 10; i++) push(rnd(), 1'b0, ov(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    push(1'b1, 1'b1, 17'h0);
    run_queue();
    set_instr(7'b1101111, 3'd0, 4'b0000);
    model_instr(7'b1101111, 3'd0, 4'b0000, 0, 0);
    run_queue();

    // Randomized instruction stream
    for (int k = 0; k < 300; k++) begin
      logic [6:0] op;
      logic [2:0] f3;
      int sel;
      sel = $urandom_range(0, 10);
      case (sel)
        0: op = 7'b0000011;
        1: op = 7'b0100011;
        2: op = 7'b0110011;
        3: op = 7'b0010011;
        4, 5: op = 7'b1100011;
        6: op = 7'b1101111;
        7: op = 7'b1100111;
        8: op = 7'b0110111;
        9: op = 7'b0010111;
        default: op = 7'($urandom_range(0, 127));
      endcase
      f3 = 3'($urandom_range(0, 7));
      nzcv = 4'($urandom_range(0, 15));
      set_instr(op, f3, nzcv);
      model_instr(op, f3, nzcv, $urandom_range(0, 2), $urandom_range(0, 3));
      run_queue();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
